// File: rtl/state_dump_ctrl_if.sv
// Record stream from the state-dump sequencer to the trace/logging sink.
interface state_dump_ctrl_if;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_tag;
   logic [15:0] out_index;
   logic [15:0] out_data;

   modport master (output out_valid, out_tag, out_index, out_data, input out_ready);
   modport slave  (input out_valid, out_tag, out_index, out_data, output out_ready);
endinterface

// File: rtl/state_dump_ctrl.sv
// State-dump sequencer: halts the pipeline, then streams RF, BHT/BTB and a
// data-memory window as tagged records over a valid/ready stream.
module state_dump_ctrl #(
   parameter logic [15:0] MEM_BASE  = 16'h0000,
   parameter int unsigned MEM_WORDS = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      dump_req,
   output logic                      halt_req,
   input  logic                      halt_ack,
   output logic [3:0]                rf_addr,
   input  logic [15:0]               rf_data,
   output logic [3:0]                bp_idx,
   input  logic [1:0]                bht_data,
   input  logic [15:0]               btb_data,
   output logic                      dm_rd_en,
   output logic [15:0]               dm_addr,
   input  logic [15:0]               dm_data,
   state_dump_ctrl_if.master         sink,
   output logic [31:0]               dump_cycle,
   output logic                      busy,
   output logic                      done,
   output logic                      dump_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_HALT, S_RF, S_BP, S_DM_RD, S_DM_CAP, S_DRAIN, S_DONE
   } state_t;

   localparam logic [16:0] LAST_K = 17'(MEM_WORDS);

   state_t      state;
   logic [31:0] cnt;
   logic        bp_sel;
   logic [16:0] k;
   logic [15:0] dm_val;
   logic        cap_vld;
   logic        valid_q;
   logic [1:0]  tag_q;
   logic [15:0] index_q;
   logic [15:0] data_q;

   logic        slot;
   logic        abort;
   logic        ld;
   logic [1:0]  ld_tag;
   logic [15:0] ld_index;
   logic [15:0] ld_data;

   assign sink.out_valid = valid_q;
   assign sink.out_tag   = tag_q;
   assign sink.out_index = index_q;
   assign sink.out_data  = data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt + 32'd1;
   end

   // HALT loads RF entry 0 on the acknowledging cycle so the first record
   // appears one cycle after halt_ack; rf_addr is parked at 0 while idle.
   always_comb begin
      slot     = !valid_q || sink.out_ready;
      abort    = halt_req && !halt_ack &&
                 (state inside {S_RF, S_BP, S_DM_RD, S_DM_CAP, S_DRAIN});
      ld       = 1'b0;
      ld_tag   = 2'd0;
      ld_index = '0;
      ld_data  = '0;
      case (state)
         S_HALT, S_RF: begin
            ld       = slot && halt_ack;
            ld_tag   = 2'd0;
            ld_index = {12'h000, rf_addr};
            ld_data  = rf_data;
         end
         S_BP: begin
            ld       = slot;
            ld_tag   = bp_sel ? 2'd2 : 2'd1;
            ld_index = {12'h000, bp_idx};
            ld_data  = bp_sel ? btb_data : {14'h0000, bht_data};
         end
         S_DM_CAP: begin
            ld       = slot;
            ld_tag   = 2'd3;
            ld_index = dm_addr;
            ld_data  = cap_vld ? dm_val : dm_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         halt_req   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         dump_err   <= 1'b0;
         dump_cycle <= '0;
         rf_addr    <= '0;
         bp_idx     <= '0;
         bp_sel     <= 1'b0;
         dm_rd_en   <= 1'b0;
         dm_addr    <= '0;
         k          <= '0;
         dm_val     <= '0;
         cap_vld    <= 1'b0;
         valid_q    <= 1'b0;
         tag_q      <= '0;
         index_q    <= '0;
         data_q     <= '0;
      end else begin
         done     <= 1'b0;
         dm_rd_en <= 1'b0;

         if (abort) begin
            valid_q <= 1'b0;
         end else if (ld) begin
            valid_q <= 1'b1;
            tag_q   <= ld_tag;
            index_q <= ld_index;
            data_q  <= ld_data;
         end else if (sink.out_ready) begin
            valid_q <= 1'b0;
         end

         if (abort) begin
            dump_err <= 1'b1;
            done     <= 1'b1;
            halt_req <= 1'b0;
            state    <= S_DONE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (dump_req) begin
                     dump_cycle <= cnt;
                     dump_err   <= 1'b0;
                     halt_req   <= 1'b1;
                     busy       <= 1'b1;
                     rf_addr    <= '0;
                     state      <= S_HALT;
                  end
               end
               S_HALT: begin
                  if (ld) begin
                     rf_addr <= rf_addr + 4'd1;
                     state   <= S_RF;
                  end
               end
               S_RF: begin
                  if (ld) begin
                     rf_addr <= rf_addr + 4'd1;
                     if (rf_addr == 4'hF) begin
                        bp_idx <= '0;
                        bp_sel <= 1'b0;
                        state  <= S_BP;
                     end
                  end
               end
               S_BP: begin
                  if (ld) begin
                     bp_sel <= !bp_sel;
                     if (bp_sel) begin
                        bp_idx <= bp_idx + 4'd1;
                        if (bp_idx == 4'hF) begin
                           dm_rd_en <= 1'b1;
                           dm_addr  <= MEM_BASE;
                           k        <= '0;
                           state    <= S_DM_RD;
                        end
                     end
                  end
               end
               S_DM_RD: begin
                  cap_vld <= 1'b0;
                  state   <= S_DM_CAP;
               end
               S_DM_CAP: begin
                  // dm_data is only valid on the first DM_CAP cycle; keep it across stalls.
                  if (!cap_vld) begin
                     dm_val  <= dm_data;
                     cap_vld <= 1'b1;
                  end
                  if (ld) begin
                     cap_vld <= 1'b0;
                     k       <= k + 17'd1;
                     if (k + 17'd1 == LAST_K) begin
                        state <= S_DRAIN;
                     end else begin
                        dm_rd_en <= 1'b1;
                        dm_addr  <= dm_addr + 16'd1;
                        state    <= S_DM_RD;
                     end
                  end
               end
               S_DRAIN: begin
                  if (!valid_q) begin
                     done     <= 1'b1;
                     halt_req <= 1'b0;
                     state    <= S_DONE;
                  end
               end
               S_DONE: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_state_dump_ctrl.sv
// Scoreboard bench for state_dump_ctrl: two instances in lockstep, one with a
// plain DM window at 0x0010 and one whose window wraps past 0xFFFF.
module tb_state_dump_ctrl;

   typedef struct packed {
      logic [1:0]  tag;
      logic [15:0] idx;
      logic [15:0] data;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dump_req = 1'b0;
   logic halt_ack = 1'b0;
   logic out_ready = 1'b1;
   logic bp_mode = 1'b0;
   always #5 clk = ~clk;

   logic        halt_req0, halt_req1, dm_rd_en0, dm_rd_en1;
   logic        busy0, busy1, done0, done1, dump_err0, dump_err1;
   logic [3:0]  rf_addr0, rf_addr1, bp_idx0, bp_idx1;
   logic [15:0] rf_data0, rf_data1, btb_data0, btb_data1;
   logic [1:0]  bht_data0, bht_data1;
   logic [15:0] dm_addr0, dm_addr1, dm_q0, dm_q1;
   logic [31:0] dump_cycle0, dump_cycle1;
   logic [31:0] tb_cnt;

   state_dump_ctrl_if if0();
   state_dump_ctrl_if if1();
   assign if0.out_ready = out_ready;
   assign if1.out_ready = out_ready;

   function automatic logic [15:0] rf_fn(input logic [3:0] a);
      return {4'hA, a, ~a, a};
   endfunction
   function automatic logic [1:0] bht_fn(input logic [3:0] a);
      return a[1:0] ^ a[3:2];
   endfunction
   function automatic logic [15:0] btb_fn(input logic [3:0] a);
      return {4'h8, a, 4'h0, ~a};
   endfunction
   function automatic logic [15:0] dm_fn(input logic [15:0] addr);
      return addr ^ 16'h5A3C;
   endfunction

   assign rf_data0  = rf_fn(rf_addr0);
   assign rf_data1  = rf_fn(rf_addr1);
   assign bht_data0 = bht_fn(bp_idx0);
   assign bht_data1 = bht_fn(bp_idx1);
   assign btb_data0 = btb_fn(bp_idx0);
   assign btb_data1 = btb_fn(bp_idx1);

   // Memory returns valid data only the cycle after a read strobe.
   always @(posedge clk) begin
      dm_q0 <= dm_rd_en0 ? dm_fn(dm_addr0) : 16'hDEAD;
      dm_q1 <= dm_rd_en1 ? dm_fn(dm_addr1) : 16'hDEAD;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_cnt <= '0;
      else        tb_cnt <= tb_cnt + 32'd1;
   end

   state_dump_ctrl #(.MEM_BASE(16'h0010), .MEM_WORDS(4)) u0 (
      .clk(clk), .rst_n(rst_n), .dump_req(dump_req), .halt_req(halt_req0),
      .halt_ack(halt_ack), .rf_addr(rf_addr0), .rf_data(rf_data0),
      .bp_idx(bp_idx0), .bht_data(bht_data0), .btb_data(btb_data0),
      .dm_rd_en(dm_rd_en0), .dm_addr(dm_addr0), .dm_data(dm_q0), .sink(if0),
      .dump_cycle(dump_cycle0), .busy(busy0), .done(done0), .dump_err(dump_err0));

   state_dump_ctrl #(.MEM_BASE(16'hFFFE), .MEM_WORDS(4)) u1 (
      .clk(clk), .rst_n(rst_n), .dump_req(dump_req), .halt_req(halt_req1),
      .halt_ack(halt_ack), .rf_addr(rf_addr1), .rf_data(rf_data1),
      .bp_idx(bp_idx1), .bht_data(bht_data1), .btb_data(btb_data1),
      .dm_rd_en(dm_rd_en1), .dm_addr(dm_addr1), .dm_data(dm_q1), .sink(if1),
      .dump_cycle(dump_cycle1), .busy(busy1), .done(done1), .dump_err(dump_err1));

   int   n_cmp = 0;
   int   n_bad = 0;
   int   done_cnt = 0;
   rec_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // The wrapping instance sees the same record stream except for the DM window.
   function automatic rec_t to_wrap(input rec_t e);
      rec_t r;
      r = e;
      if (e.tag == 2'd3) begin
         r.idx  = e.idx - 16'h0010 + 16'hFFFE;
         r.data = dm_fn(r.idx);
      end
      return r;
   endfunction

   logic prev_v = 1'b0;
   logic prev_r = 1'b0;
   rec_t prev_rec;

   always @(negedge clk) begin
      rec_t cur0, cur1, e;
      cur0 = {if0.out_tag, if0.out_index, if0.out_data};
      cur1 = {if1.out_tag, if1.out_index, if1.out_data};
      if (rst_n) begin
         if (done0) begin
            done_cnt++;
            check("halt_req_at_done", {63'd0, halt_req0}, 64'd0);
            check("busy_at_done", {63'd0, busy0}, 64'd1);
         end
         if (prev_v && !prev_r && halt_ack) begin
            check("stall_valid", {63'd0, if0.out_valid}, 64'd1);
            check("stall_record", {30'd0, cur0}, {30'd0, prev_rec});
         end
         if (if0.out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_record: actual=%0h required=none", cur0);
            end else begin
               e = exp_q.pop_front();
               check("record_dut0", {30'd0, cur0}, {30'd0, e});
               check("record_wrap", {30'd0, cur1}, {30'd0, to_wrap(e)});
            end
         end
         prev_v   = if0.out_valid;
         prev_r   = out_ready;
         prev_rec = cur0;
      end else begin
         prev_v = 1'b0;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1 out_ready = bp_mode ? ($urandom_range(0, 9) >= 3) : 1'b1;
      end
   end

   // mode 0: normal dump, 1: abort during BP, 2: reset during DM
   task automatic do_dump(input logic bp, input int mode);
      logic [31:0] t_acc, t_ack, t_done;
      int start_done;
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back({2'd0, 16'(i), rf_fn(4'(i))});
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({2'd1, 16'(i), {14'd0, bht_fn(4'(i))}});
         exp_q.push_back({2'd2, 16'(i), btb_fn(4'(i))});
      end
      for (int k = 0; k < 4; k++) exp_q.push_back({2'd3, 16'h0010 + 16'(k), dm_fn(16'h0010 + 16'(k))});
      bp_mode    = bp;
      start_done = done_cnt;

      @(posedge clk);
      #1 dump_req = 1'b1;
      t_acc = tb_cnt;
      @(posedge clk);
      #1 dump_req = 1'b0;
      check("halt_req_after_req", {63'd0, halt_req0}, 64'd1);
      check("busy_after_req", {63'd0, busy0}, 64'd1);
      check("dump_cycle", {32'd0, dump_cycle0}, {32'd0, t_acc});
      check("dump_cycle_wrap", {32'd0, dump_cycle1}, {32'd0, t_acc});
      check("dump_err_cleared", {63'd0, dump_err0}, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 halt_ack = 1'b1;
      t_ack = tb_cnt;

      if (mode == 0 && !bp) begin
         @(negedge clk);
         check("valid_at_ack", {63'd0, if0.out_valid}, 64'd0);
         @(negedge clk);
         check("first_rf_valid", {63'd0, if0.out_valid}, 64'd1);
         repeat (5) @(posedge clk);
         #1 dump_req = 1'b1;
         @(posedge clk);
         #1 dump_req = 1'b0;
      end

      if (mode == 2) begin
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if0.out_valid && if0.out_tag == 2'd3) break;
         end
         check("reached_dm", {62'd0, if0.out_tag}, 64'd3);
         #2 rst_n = 1'b0;
         #1;
         check("rst_halt_busy_done", {61'd0, halt_req0, busy0, done0}, 64'd0);
         check("rst_valid_rd", {62'd0, if0.out_valid, dm_rd_en0}, 64'd0);
         check("rst_record", {30'd0, if0.out_tag, if0.out_index, if0.out_data}, 64'd0);
         check("rst_addrs", {24'd0, rf_addr0, bp_idx0, dm_addr0}, 64'd0);
         check("rst_stamp_err", {31'd0, dump_cycle0, dump_err0}, 64'd0);
         exp_q.delete();
         halt_ack = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         repeat (5) @(negedge clk);
         check("no_done_after_reset", 64'(done_cnt - start_done), 64'd0);
         check("idle_after_reset", {62'd0, busy0, halt_req0}, 64'd0);
         return;
      end

      if (mode == 1) begin
         repeat (20) @(posedge clk);
         check("abort_in_bp", {63'd0, (if0.out_tag == 2'd1 || if0.out_tag == 2'd2)}, 64'd1);
         #1 halt_ack = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check("abort_valid_drop", {63'd0, if0.out_valid}, 64'd0);
         check("abort_err_done", {62'd0, dump_err0, done0}, 64'd3);
         exp_q.delete();
      end else begin
         for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done0) break;
         end
         check("done_seen", {63'd0, done0}, 64'd1);
         t_done = tb_cnt;
         if (!bp) check("dump_length", {32'd0, t_done - t_ack}, 64'd58);
      end

      @(posedge clk);
      #1 halt_ack = 1'b0;
      check("busy_falls", {62'd0, busy0, done0}, 64'd0);
      repeat (6) @(negedge clk);
      check("one_done_pulse", 64'(done_cnt - start_done), 64'd1);
      check("no_second_dump", {62'd0, busy0, halt_req0}, 64'd0);
      check("records_left", 64'(exp_q.size()), 64'd0);
      check("dump_err_final", {63'd0, dump_err0}, (mode == 1) ? 64'd1 : 64'd0);
   endtask

   initial begin
      #3;
      check("reset_ctrl", {60'd0, halt_req0, busy0, done0, dump_err0}, 64'd0);
      check("reset_out", {31'd0, if0.out_valid, dump_cycle0}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_reset_release", {62'd0, busy0, if0.out_valid}, 64'd0);

      do_dump(1'b0, 0);
      do_dump(1'b1, 0);
      do_dump(1'b0, 1);
      do_dump(1'b0, 0);
      do_dump(1'b0, 2);
      bp_mode = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/state_dump_ctrl.md
# state_dump_ctrl

Hardware state-dump sequencer for the pipelined CPU. On a dump request it halts the pipeline, then reads the register file, the BHT/BTB branch-predictor tables and a configurable data-memory window in a fixed order. It streams each entry as a tagged record over a valid/ready interface to the trace/logging sink. It sits beside the CPU core, owns the debug read ports of those structures while busy, and releases the pipeline when the sequence is complete.

## Interface
Parameters:
- MEM_BASE, 16'h0000, first data-memory word address dumped
- MEM_WORDS, 16, number of data-memory words dumped (legal 1..65536)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dump_req  in  1  start request, sampled only in IDLE
- halt_req  out  1  pipeline halt request
- halt_ack  in  1  pipeline drained and frozen; must stay high while halt_req is high
- rf_addr  out  4  register-file debug read address (combinational read)
- rf_data  in  16  register-file read data
- bp_idx  out  4  BHT/BTB debug index (combinational read)
- bht_data  in  2  BHT 2-bit counter
- btb_data  in  16  BTB target
- dm_rd_en  out  1  data-memory debug read strobe
- dm_addr  out  16  data-memory debug address
- dm_data  in  16  data-memory read data, valid the cycle after dm_rd_en
- out_valid  out  1  record valid
- out_ready  in  1  sink accepts record
- out_tag  out  2  0=RF, 1=BHT, 2=BTB, 3=DM
- out_index  out  16  register number, table index or memory address
- out_data  out  16  value; BHT zero-extended from 2 bits
- dump_cycle  out  32  free-running cycle count captured at request acceptance
- busy  out  1  high from acceptance until the DONE cycle inclusive
- done  out  1  one-cycle completion pulse
- dump_err  out  1  sticky abort flag; cleared at the next acceptance

## Operation
- Reset: all outputs 0; state IDLE; cycle counter 0.
- Cycle counter: 32-bit, increments every cycle, wraps at 2^32.
- States: IDLE, HALT, RF, BP, DM_RD, DM_CAP, DRAIN, DONE.
- IDLE: when dump_req=1, capture the counter into dump_cycle, clear dump_err, go to HALT. dump_req in any other state is ignored.
- HALT: halt_req=1, which stays high through DONE. Wait for halt_ack=1, then go to RF.
- Output register: holds tag/index/data. A new record loads only when out_valid=0 or out_ready=1, called a "slot". The record holds stable while out_valid && !out_ready.
- RF: on each slot emit {0, i, rf_data} with rf_addr=i, for i=0..15. After i=15, go to BP.
- BP: for idx 0..15, emit {1, idx, bht_data} on one slot, then {2, idx, btb_data} on the next. This gives 32 records. After the last record, go to DM_RD.
- DM_RD: assert dm_rd_en for one cycle with dm_addr = MEM_BASE + k (mod 2^16), then go to DM_CAP.
- DM_CAP: latch dm_data internally. On a slot, emit {3, dm_addr, value}. Then k++. If k=MEM_WORDS go to DRAIN, else go to DM_RD. Use a 17-bit counter for k.
- DRAIN: wait until out_valid=0, meaning the last record was accepted, then go to DONE.
- DONE: pulse done and drop halt_req; busy falls next cycle; return to IDLE.
- Abort: if halt_ack falls in any state after HALT:
  - clear out_valid without a handshake;
  - set dump_err;
  - go to DONE.
  - The record in flight is lost.
- Reset mid-dump: halt_req, out_valid and busy drop immediately (asynchronously). No done pulse is produced.

## Timing
- dump_req at cycle t leads to halt_req=1 and busy=1 at t+1.
- halt_ack high at cycle h leads to the first RF record valid at h+1.
- With out_ready tied high:
  - RF and BP emit 1 record per cycle;
  - DM emits 1 record per 2 cycles.
- Total records = 48 + MEM_WORDS.
- Minimum dump length with out_ready=1, from halt_ack to done: 48 + 2*MEM_WORDS + 2 cycles.
- Back-pressure: each cycle out_ready=0 while out_valid=1 stalls the sequence by one cycle.
  - RF/BP addresses do not advance.
  - DM_CAP holds its latched value. dm_rd_en is not re-issued.
- dm_rd_en is never asserted outside DM_RD.

## Test plan
- Basic dump, MEM_BASE=0x0010, MEM_WORDS=4, out_ready=1, halt_ack 2 cycles after halt_req. Required:
  - 52 records in order: RF 0..15, then BHT/BTB interleaved for indices 0..15, then DM 0x0010..0x0013;
  - values match the preloaded contents;
  - done asserts once and halt_req drops with done.
- Back-pressure: out_ready toggles in a random 30% low pattern. Required:
  - identical 52-record sequence;
  - no record is dropped or duplicated;
  - the record is stable while stalled.
- Address wrap, MEM_BASE=0xFFFE, MEM_WORDS=4. Required: DM addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Abort: drop halt_ack during the BP phase. Required:
  - out_valid falls the next cycle;
  - dump_err=1 and one done pulse;
  - a subsequent dump clears dump_err and completes normally.
- Reset and cycle stamp:
  - Required: dump_cycle equals the acceptance cycle count.
  - Assert rst_n=0 mid-DM. Required: all outputs are 0 immediately.
  - Raise dump_req during busy. Required: it is ignored and no second dump starts.
